// File: rtl/uart_pkg.sv
// uart_pkg: shared types and build-time limits for the UART receivers.
// Parity decode keeps the unused 2'b11 encoding mapped to "no parity".
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;

    function automatic parity_mode_e decode_parity(input logic [1:0] cfg);
        parity_mode_e m;
        case (cfg)
            2'b01:   m = PAR_EVEN;
            2'b10:   m = PAR_ODD;
            default: m = PAR_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop line synchroniser, falling-edge detect and a
// three-sample majority voter whose third vote is the live synced level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic samp_i,
    output logic rx_o,
    output logic fall_o,
    output logic vote_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic [1:0] hist_q;

    // Synchronise the line, remember last level, keep two earlier samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= sync_q[1];
            if (samp_i) begin
                hist_q <= {hist_q[0], sync_q[1]};
            end
        end
    end

    assign rx_o   = sync_q[1];
    assign fall_o = prev_q & ~sync_q[1];
    assign vote_o = (hist_q[1] & hist_q[0])
                  | (hist_q[1] & sync_q[1])
                  | (hist_q[0] & sync_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver, run-time parity/stop config,
// parity/frame/break/overrun status and a single valid/ready output word.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 os_tick,
    input  logic                 rx,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_LO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_DEC = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    parity_mode_e         par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 pbit_q, pbit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 perr_o_q, perr_o_d;
    logic                 ferr_o_q, ferr_o_d;
    logic                 brk_o_q, brk_o_d;
    logic                 ovr_q, ovr_d;

    logic rx_s, rx_fall, vote;
    logic in_bit, samp, decide, bit_end;

    uart_rx_sync u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .rx_i   (rx),
        .samp_i (samp),
        .rx_o   (rx_s),
        .fall_o (rx_fall),
        .vote_o (vote)
    );

    assign in_bit  = (state_q == DATA) || (state_q == PARITY)
                   || (state_q == STOP && !done_q);
    assign samp    = os_tick && in_bit
                   && (cnt_q == T_LO || cnt_q == T_MID || cnt_q == T_DEC);
    assign decide  = os_tick && in_bit && (cnt_q == T_DEC);
    assign bit_end = os_tick && (cnt_q == T_END);

    // Next-state, frame accumulation and output-register handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        pbit_d   = pbit_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        brk_d    = brk_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        valid_d  = valid_q && !ready;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        brk_o_d  = brk_o_q;
        ovr_d    = 1'b0;

        if (!en && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en && rx_fall) begin
                        state_d = START;
                        cnt_d   = '0;
                        bit_d   = '0;
                        par_d   = decode_parity(cfg_parity);
                        stop2_d = cfg_stop2;
                        pbit_d  = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        brk_d   = 1'b0;
                    end
                end
                START: begin
                    if (os_tick) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == T_MID && rx_s) begin
                            state_d = IDLE;
                        end else if (cnt_q == T_END) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end
                end
                DATA: begin
                    if (os_tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (decide) begin
                        sh_d = {vote, sh_q[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = (par_q == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (os_tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (decide) begin
                        pbit_d = vote;
                        perr_d = (^sh_q) ^ vote ^ (par_q == PAR_ODD);
                    end
                    if (bit_end) begin
                        cnt_d   = '0;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (done_q) begin
                        state_d = ferr_q ? WAIT_IDLE : IDLE;
                        if (!valid_q || ready) begin
                            dout_d   = sh_q;
                            perr_o_d = perr_q;
                            ferr_o_d = ferr_q;
                            brk_o_d  = brk_q;
                            valid_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        if (os_tick) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (decide) begin
                            if (!vote) begin
                                ferr_d = 1'b1;
                            end
                            if (bit_q == '0 && !vote
                                && sh_q == '0 && !pbit_q) begin
                                brk_d = 1'b1;
                            end
                            if (bit_q != '0 || !stop2_q) begin
                                done_d = 1'b1;
                            end
                        end
                        if (bit_end) begin
                            cnt_d = '0;
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, frame and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            pbit_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            brk_o_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            pbit_q   <= pbit_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            brk_q    <= brk_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            brk_o_q  <= brk_o_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign valid      = valid_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign break_det  = brk_o_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table vectors, hand sequences and random frames
// checked against a frame-level reference model.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, os_tick, rx8, rx7, cfg_stop2, ready8, ready7;
    logic [1:0] cfg_par;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic v8, pe8, fe8, bk8, ov8, busy8;
    logic v7, pe7, fe7, bk7, ov7, busy7;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
        .clk(clk), .rst(rst), .en(en), .os_tick(os_tick), .rx(rx8),
        .cfg_parity(cfg_par), .cfg_stop2(cfg_stop2), .data_out(dout8),
        .valid(v8), .ready(ready8), .parity_err(pe8), .frame_err(fe8),
        .break_det(bk8), .overrun(ov8), .busy(busy8));

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
        .clk(clk), .rst(rst), .en(en), .os_tick(os_tick), .rx(rx7),
        .cfg_parity(cfg_par), .cfg_stop2(cfg_stop2), .data_out(dout7),
        .valid(v7), .ready(ready7), .parity_err(pe7), .frame_err(fe7),
        .break_det(bk7), .overrun(ov7), .busy(busy7));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rises8 = 0, rises7 = 0, rise8 = 0, rise7 = 0, ovr8 = 0;
    logic pv8 = 1'b0, pv7 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v8 && !pv8) begin rises8 = rises8 + 1; rise8 = cyc; end
        if (v7 && !pv7) begin rises7 = rises7 + 1; rise7 = cyc; end
        if (ov8) ovr8 = ovr8 + 1;
        pv8 = v8;
        pv7 = v7;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic [1:0] par;
        logic       pb;
        logic       s1;
        logic       st2;
        logic       pe;
        logic       fe;
        logic       bk;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: frame flags {perr, ferr, brk} from the bits put on the line.
    function automatic logic [2:0] model(input logic [8:0] d, input int nb,
                                         input logic [1:0] par, input logic pb,
                                         input logic s1, input logic st2,
                                         input logic s2);
        logic ones, any, pen, perr, ferr, brk;
        ones = 1'b0;
        any  = 1'b0;
        for (int i = 0; i < nb; i++) begin
            ones = ones ^ d[i];
            any  = any | d[i];
        end
        pen  = (par == 2'b01) || (par == 2'b10);
        perr = pen && ((par == 2'b01) ? (ones ^ pb) : !(ones ^ pb));
        ferr = !s1 || (st2 && !s2);
        brk  = !any && !(pen && pb) && !s1;
        return {perr, ferr, brk};
    endfunction

    function automatic int exp_lat(input int nb, input logic [1:0] par,
                                   input logic st2);
        int p;
        p = ((par == 2'b01) || (par == 2'b10)) ? 1 : 0;
        return 16 * (1 + nb + p + int'(st2)) + 13;
    endfunction

    task automatic drive_bit(input bit sel, input logic b);
        if (sel) rx7 = b; else rx8 = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [8:0] d, input int nb,
                        input logic [1:0] par, input logic pb, input logic s1,
                        input logic st2, input logic s2);
        cfg_par   = par;
        cfg_stop2 = st2;
        start_cyc = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
        if (par == 2'b01 || par == 2'b10) drive_bit(sel, pb);
        drive_bit(sel, s1);
        if (st2) drive_bit(sel, s2);
        if (sel) rx7 = 1'b1; else rx8 = 1'b1;
    endtask

    task automatic expect_word(input bit sel, input string tag, input int ed,
                               input logic [2:0] ef, input int elat,
                               input bit consume);
        int n;
        int lat;
        logic v;
        n = 0;
        while (((sel ? v7 : v8) !== 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        #1;
        v = sel ? v7 : v8;
        chk({tag, ".valid"}, int'(v), 1);
        if (v === 1'b1) begin
            chk({tag, ".data"}, sel ? int'(dout7) : int'(dout8), ed);
            chk({tag, ".perr"}, int'(sel ? pe7 : pe8), int'(ef[2]));
            chk({tag, ".ferr"}, int'(sel ? fe7 : fe8), int'(ef[1]));
            chk({tag, ".brk"}, int'(sel ? bk7 : bk8), int'(ef[0]));
            lat = (sel ? rise7 : rise8) - (start_cyc + 1);
            checks++;
            if (lat < elat - 2 || lat > elat + 2) begin
                errors++;
                $display("FAIL %s.latency: got %0d expected %0d +-2",
                         tag, lat, elat);
            end
        end
        if (consume) begin
            @(negedge clk);
            if (sel) ready7 = 1'b1; else ready8 = 1'b1;
            @(negedge clk);
            ready7 = 1'b0;
            ready8 = 1'b0;
            chk({tag, ".drop"}, int'(sel ? v7 : v8), 0);
        end
    endtask

    initial begin
        int r0, o0;
        logic [8:0] d;
        logic [1:0] par;
        logic pb, s1, s2, st2;

        rst = 1'b1; en = 1'b1; os_tick = 1'b1;
        rx8 = 1'b1; rx7 = 1'b1; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        ready8 = 1'b0; ready7 = 1'b0;

        tbl[0] = '{8'hAE, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h55, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'h01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'hC3, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst.valid", int'(v8), 0);
        chk("rst.busy", int'(busy8), 0);
        chk("rst.data", int'(dout8), 0);
        chk("rst.flags", int'({pe8, fe8, bk8, ov8}), 0);
        chk("rst.valid7", int'(v7), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table vectors on the 8-bit receiver.
        for (int i = 0; i < 10; i++) begin
            send(1'b0, {1'b0, tbl[i].d}, 8, tbl[i].par, tbl[i].pb,
                 tbl[i].s1, tbl[i].st2, 1'b1);
            expect_word(1'b0, $sformatf("tbl%0d", i), int'(tbl[i].d),
                        {tbl[i].pe, tbl[i].fe, tbl[i].bk},
                        exp_lat(8, tbl[i].par, tbl[i].st2), 1'b1);
            repeat (32) @(negedge clk);
        end

        // Break: zero data, zero parity, line held low 40 more bits.
        r0 = rises8;
        cfg_par = 2'b01;
        cfg_stop2 = 1'b0;
        rx8 = 1'b0;
        repeat (16 * 30) @(negedge clk);
        #1;
        chk("brk.valid", int'(v8), 1);
        chk("brk.data", int'(dout8), 0);
        chk("brk.ferr", int'(fe8), 1);
        chk("brk.det", int'(bk8), 1);
        chk("brk.perr", int'(pe8), 0);
        @(negedge clk) ready8 = 1'b1;
        @(negedge clk) ready8 = 1'b0;
        repeat (16 * 20) @(negedge clk);
        chk("brk.busy_held", int'(busy8), 1);
        chk("brk.words", rises8 - r0, 1);
        rx8 = 1'b1;
        repeat (4) @(negedge clk);
        chk("brk.busy_drop", int'(busy8), 0);
        repeat (300) @(negedge clk);
        chk("brk.words_after", rises8 - r0, 1);

        // Glitch: 5 clk low pulse must be rejected as a false start.
        r0 = rises8;
        rx8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch.busy_up", int'(busy8), 1);
        @(negedge clk) rx8 = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch.busy_down", int'(busy8), 0);
        repeat (200) @(negedge clk);
        chk("glitch.no_word", rises8 - r0, 0);
        send(1'b0, 9'h03C, 8, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_word(1'b0, "glitch.next", 'h3C, 3'b000,
                    exp_lat(8, 2'b01, 1'b0), 1'b1);
        repeat (32) @(negedge clk);

        // Overrun: two back-to-back frames with ready held low.
        o0 = ovr8;
        send(1'b0, 9'h011, 8, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        send(1'b0, 9'h022, 8, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        chk("ovr.pulses", ovr8 - o0, 1);
        chk("ovr.valid", int'(v8), 1);
        chk("ovr.data", int'(dout8), 'h11);
        ready8 = 1'b1;
        @(negedge clk) ready8 = 1'b0;
        chk("ovr.xfer", int'(v8), 0);
        repeat (32) @(negedge clk);

        // Random frames against the reference model.
        for (int k = 0; k < 14; k++) begin
            d   = 9'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) d = '0;
            par = 2'($urandom_range(0, 3));
            pb  = 1'($urandom_range(0, 1));
            s1  = ($urandom_range(0, 3) != 0);
            st2 = 1'($urandom_range(0, 1));
            s2  = ($urandom_range(0, 3) != 0);
            send(1'b0, d, 8, par, pb, s1, st2, s2);
            expect_word(1'b0, $sformatf("rnd%0d", k), int'(d[7:0]),
                        model(d, 8, par, pb, s1, st2, s2),
                        exp_lat(8, par, st2), 1'b1);
            repeat (20) @(negedge clk);
        end

        // 7-bit receiver, no parity, two stop bits.
        send(1'b1, 9'h041, 7, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_word(1'b1, "d7.ok", 'h41, 3'b000,
                    exp_lat(7, 2'b00, 1'b1), 1'b1);
        repeat (32) @(negedge clk);
        send(1'b1, 9'h041, 7, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_word(1'b1, "d7.stop2", 'h41, 3'b010,
                    exp_lat(7, 2'b00, 1'b1), 1'b0);
        repeat (32) @(negedge clk);

        // Reset in the middle of a frame clears everything at once.
        rx7 = 1'b0;
        repeat (16 * 4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("d7.rst.valid", int'(v7), 0);
        chk("d7.rst.data", int'(dout7), 0);
        chk("d7.rst.flags", int'({pe7, fe7, bk7, ov7}), 0);
        chk("d7.rst.busy", int'(busy7), 0);
        @(negedge clk);
        rst = 1'b0;
        rx7 = 1'b1;
        repeat (32) @(negedge clk);
        send(1'b1, 9'h041, 7, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_word(1'b1, "d7.after_rst", 'h41, 3'b000,
                    exp_lat(7, 2'b00, 1'b1), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
